// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg
//   Shared definitions for the MM:SS countdown timer service.
//   - state_t : controller states (3-bit encoding, unused codes recover to IDLE)
//   - event_t : the single button event acting in a cycle, after prioritisation
//   - BCD display word field boundaries, shared with the stopwatch service
//   - per-digit BCD limits and a helper returning the limit of a selected digit
package countdown_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET     = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_EXPIRED = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE = 3'd0,
    EV_M    = 3'd1,
    EV_U    = 3'd2,
    EV_D    = 3'd3,
    EV_L    = 3'd4,
    EV_R    = 3'd5
  } event_t;

  // 16-bit BCD display word layout (same as the stopwatch count)
  localparam int BCD_W         = 16;
  localparam int DIGIT_W       = 4;
  localparam int MIN_TENS_LSB  = 12;
  localparam int MIN_UNITS_LSB = 8;
  localparam int SEC_TENS_LSB  = 4;
  localparam int SEC_UNITS_LSB = 0;

  // Largest legal value of each digit
  localparam logic [3:0] MIN_TENS_MAX  = 4'd5;
  localparam logic [3:0] MIN_UNITS_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX  = 4'd5;
  localparam logic [3:0] SEC_UNITS_MAX = 4'd9;

  // digit_sel 3 addresses [15:12], 0 addresses [3:0]
  function automatic logic [3:0] digit_max(input logic [1:0] sel);
    logic [3:0] lim;
    case (sel)
      2'd3:    lim = MIN_TENS_MAX;
      2'd2:    lim = MIN_UNITS_MAX;
      2'd1:    lim = SEC_TENS_MAX;
      default: lim = SEC_UNITS_MAX;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// btn_edge_detect
//   Registered rising-edge detector for one level-sensitive push button.
//   A button held high yields exactly one single-cycle press pulse.
//   Ports:
//     clk    in  system clock
//     reset  in  asynchronous, active-high reset (clears history)
//     clear  in  synchronous clear of the history (service deselected)
//     btn    in  raw button level
//     press  out one-cycle pulse: btn & ~btn_q
module btn_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic btn,
  output logic press
);

  logic btn_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q <= 1'b0;
    end else if (clear) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn;
    end
  end

  assign press = btn & ~btn_q;

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer
//   BCD MM:SS countdown timer. The user programs a start time digit by digit
//   in SET, starts/pauses with push_m, and the block raises alarm at 00:00.
//   Ports:
//     clk, reset      clock, asynchronous active-high reset
//     enable          service select; low clears the block to IDLE
//     push_m          start / pause / acknowledge (level)
//     push_u, push_d  increment / decrement selected digit (level)
//     push_l, push_r  move digit selection left / right (level)
//     time_bcd        {min tens, min units, sec tens, sec units}
//     digit_sel       selected digit, 3 = [15:12], 0 = [3:0]
//     blink_en        high in SET
//     alarm           high in EXPIRED
//     running         high in RUN
//   Parameters:
//     PRESC  clk cycles per one-second decrement (>= 1)
//     PW     prescaler width, 2^PW >= PRESC
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int PRESC = 1,
  parameter int PW    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        push_m,
  input  logic        push_u,
  input  logic        push_d,
  input  logic        push_l,
  input  logic        push_r,
  output logic [15:0] time_bcd,
  output logic [1:0]  digit_sel,
  output logic        blink_en,
  output logic        alarm,
  output logic        running
);

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   preset_q, preset_d;
  logic [1:0]         sel_q, sel_d;
  logic [PW-1:0]      presc_q, presc_d;

  logic press_m, press_u, press_d, press_l, press_r;
  event_t             ev;
  logic [BCD_W-1:0]   bcd_dec_val;
  logic               tick;
  logic [DIGIT_W-1:0] cur_digit;
  logic [DIGIT_W-1:0] cur_max;

  // One-second BCD decrement with borrow through all four digits.
  // Only applied to a non-zero value.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[SEC_UNITS_LSB +: DIGIT_W] != 4'd0) begin
      r[SEC_UNITS_LSB +: DIGIT_W] = t[SEC_UNITS_LSB +: DIGIT_W] - 4'd1;
    end else begin
      r[SEC_UNITS_LSB +: DIGIT_W] = SEC_UNITS_MAX;
      if (t[SEC_TENS_LSB +: DIGIT_W] != 4'd0) begin
        r[SEC_TENS_LSB +: DIGIT_W] = t[SEC_TENS_LSB +: DIGIT_W] - 4'd1;
      end else begin
        r[SEC_TENS_LSB +: DIGIT_W] = SEC_TENS_MAX;
        if (t[MIN_UNITS_LSB +: DIGIT_W] != 4'd0) begin
          r[MIN_UNITS_LSB +: DIGIT_W] = t[MIN_UNITS_LSB +: DIGIT_W] - 4'd1;
        end else begin
          r[MIN_UNITS_LSB +: DIGIT_W] = MIN_UNITS_MAX;
          r[MIN_TENS_LSB +: DIGIT_W]  = t[MIN_TENS_LSB +: DIGIT_W] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] lim);
    return (d >= lim) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] digit_dec(input logic [3:0] d, input logic [3:0] lim);
    return (d == 4'd0 || d > lim) ? lim : d - 4'd1;
  endfunction

  btn_edge_detect u_btn_m (.clk(clk), .reset(reset), .clear(~enable), .btn(push_m), .press(press_m));
  btn_edge_detect u_btn_u (.clk(clk), .reset(reset), .clear(~enable), .btn(push_u), .press(press_u));
  btn_edge_detect u_btn_d (.clk(clk), .reset(reset), .clear(~enable), .btn(push_d), .press(press_d));
  btn_edge_detect u_btn_l (.clk(clk), .reset(reset), .clear(~enable), .btn(push_l), .press(press_l));
  btn_edge_detect u_btn_r (.clk(clk), .reset(reset), .clear(~enable), .btn(push_r), .press(press_r));

  // Only the highest-priority press acts: m > u > d > l > r
  always_comb begin
    ev = EV_NONE;
    if (press_m)      ev = EV_M;
    else if (press_u) ev = EV_U;
    else if (press_d) ev = EV_D;
    else if (press_l) ev = EV_L;
    else if (press_r) ev = EV_R;
  end

  assign bcd_dec_val = bcd_dec(bcd_q);
  assign tick        = (presc_q == PRESC_LAST);
  assign cur_digit   = bcd_q[{sel_q, 2'b00} +: DIGIT_W];
  assign cur_max     = digit_max(sel_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bcd_q    <= '0;
      preset_q <= '0;
      sel_q    <= '0;
      presc_q  <= '0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      preset_q <= preset_d;
      sel_q    <= sel_d;
      presc_q  <= presc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    preset_d = preset_q;
    sel_d    = sel_q;
    presc_d  = presc_q;

    if (!enable) begin
      state_d  = ST_IDLE;
      bcd_d    = '0;
      preset_d = '0;
      sel_d    = '0;
      presc_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SET;
        end

        ST_SET: begin
          case (ev)
            EV_U: bcd_d[{sel_q, 2'b00} +: DIGIT_W] = digit_inc(cur_digit, cur_max);
            EV_D: bcd_d[{sel_q, 2'b00} +: DIGIT_W] = digit_dec(cur_digit, cur_max);
            EV_L: sel_d = sel_q + 2'd1;
            EV_R: sel_d = sel_q - 2'd1;
            EV_M: begin
              // A zero start time would expire immediately; ignore it
              if (bcd_q != '0) begin
                preset_d = bcd_q;
                presc_d  = '0;
                state_d  = ST_RUN;
              end
            end
            default: ;
          endcase
        end

        ST_RUN: begin
          if (tick) begin
            presc_d = '0;
            bcd_d   = bcd_dec_val;
          end else if (ev != EV_M) begin
            presc_d = presc_q + PW'(1);
          end
          // A pause landing on a decrement still takes the decrement;
          // reaching 00:00 wins over the pause.
          if (tick && bcd_dec_val == '0) begin
            state_d = ST_EXPIRED;
          end else if (ev == EV_M) begin
            state_d = ST_PAUSE;
          end
        end

        ST_PAUSE: begin
          case (ev)
            EV_M:       state_d = ST_RUN;
            EV_L, EV_R: state_d = ST_SET;
            default: ;
          endcase
        end

        ST_EXPIRED: begin
          if (ev == EV_M) begin
            bcd_d   = preset_q;
            state_d = ST_SET;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign time_bcd  = bcd_q;
  assign digit_sel = sel_q;
  assign blink_en  = (state_q == ST_SET);
  assign running   = (state_q == ST_RUN);
  assign alarm     = (state_q == ST_EXPIRED);

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  logic clk = 1'b0;
  logic reset, enable, push_m, push_u, push_d, push_l, push_r;

  logic [15:0] t1, t4;
  logic [1:0]  sel1, sel4;
  logic        blink1, blink4, alarm1, alarm4, run1, run4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  countdown_timer #(.PRESC(1), .PW(16)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable),
    .push_m(push_m), .push_u(push_u), .push_d(push_d), .push_l(push_l), .push_r(push_r),
    .time_bcd(t1), .digit_sel(sel1), .blink_en(blink1), .alarm(alarm1), .running(run1)
  );

  countdown_timer #(.PRESC(4), .PW(16)) u_dut4 (
    .clk(clk), .reset(reset), .enable(enable),
    .push_m(push_m), .push_u(push_u), .push_d(push_d), .push_l(push_l), .push_r(push_r),
    .time_bcd(t4), .digit_sel(sel4), .blink_en(blink4), .alarm(alarm4), .running(run4)
  );

  // ---------------- reference model (seconds-based) ----------------
  localparam int M_IDLE = 0, M_SET = 1, M_RUN = 2, M_PAUSE = 3, M_EXP = 4;
  localparam bit [4:0] BM = 5'b10000, BU = 5'b01000, BD = 5'b00100, BL = 5'b00010, BR = 5'b00001;

  int       ms   [2];
  int       dig  [2][4];
  int       pre  [2][4];
  int       sel  [2];
  int       pc   [2];
  bit [4:0] hist [2];
  int       lim  [4] = '{9, 5, 9, 5};

  logic [20:0] expq0[$];
  logic [20:0] expq1[$];

  function automatic int secs(int k);
    return (dig[k][3] * 10 + dig[k][2]) * 60 + dig[k][1] * 10 + dig[k][0];
  endfunction

  function automatic void set_secs(int k, int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    dig[k][3] = mm / 10;
    dig[k][2] = mm % 10;
    dig[k][1] = ss / 10;
    dig[k][0] = ss % 10;
  endfunction

  function automatic logic [20:0] mout(int k);
    return {4'(dig[k][3]), 4'(dig[k][2]), 4'(dig[k][1]), 4'(dig[k][0]), 2'(sel[k]),
            ms[k] == M_SET, ms[k] == M_EXP, ms[k] == M_RUN};
  endfunction

  function automatic void model_step(int k, bit r, bit en, bit [4:0] b);
    bit [4:0] pr;
    int ev, pk, s;
    pk = (k == 0) ? 1 : 4;
    if (r || !en) begin
      ms[k] = M_IDLE; sel[k] = 0; pc[k] = 0; hist[k] = '0;
      for (int i = 0; i < 4; i++) begin dig[k][i] = 0; pre[k][i] = 0; end
    end else begin
      pr = b & ~hist[k];
      hist[k] = b;
      ev = pr[4] ? 1 : pr[3] ? 2 : pr[2] ? 3 : pr[1] ? 4 : pr[0] ? 5 : 0;
      case (ms[k])
        M_IDLE: ms[k] = M_SET;
        M_SET: begin
          if (ev == 2) dig[k][sel[k]] = (dig[k][sel[k]] + 1) % (lim[sel[k]] + 1);
          else if (ev == 3) dig[k][sel[k]] = (dig[k][sel[k]] + lim[sel[k]]) % (lim[sel[k]] + 1);
          else if (ev == 4) sel[k] = (sel[k] + 1) % 4;
          else if (ev == 5) sel[k] = (sel[k] + 3) % 4;
          else if (ev == 1 && secs(k) != 0) begin
            for (int i = 0; i < 4; i++) pre[k][i] = dig[k][i];
            pc[k] = 0;
            ms[k] = M_RUN;
          end
        end
        M_RUN: begin
          if (pc[k] == pk - 1) begin
            pc[k] = 0;
            s = secs(k) - 1;
            set_secs(k, s);
            if (s == 0) ms[k] = M_EXP;
          end else if (ev != 1) begin
            pc[k] = pc[k] + 1;
          end
          if (ev == 1 && ms[k] == M_RUN) ms[k] = M_PAUSE;
        end
        M_PAUSE: begin
          if (ev == 1) ms[k] = M_RUN;
          else if (ev == 4 || ev == 5) ms[k] = M_SET;
        end
        M_EXP: begin
          if (ev == 1) begin
            for (int i = 0; i < 4; i++) dig[k][i] = pre[k][i];
            ms[k] = M_SET;
          end
        end
        default: ms[k] = M_IDLE;
      endcase
    end
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input bit r, input bit en, input bit [4:0] b);
    @(negedge clk);
    reset  = r;
    enable = en;
    {push_m, push_u, push_d, push_l, push_r} = b;
    model_step(0, r, en, b);
    model_step(1, r, en, b);
    expq0.push_back(mout(0));
    expq1.push_back(mout(1));
  endtask

  task automatic press(input bit [4:0] b);
    step(1'b0, 1'b1, b);
    step(1'b0, 1'b1, 5'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    logic [20:0] e;
    #1;
    if (expq0.size() > 0) begin
      e = expq0.pop_front();
      tests++;
      if ({t1, sel1, blink1, alarm1, run1} !== e) begin
        fails++;
        $display("FAIL presc1_outputs t=%0t: got %h expected %h", $time,
                 {t1, sel1, blink1, alarm1, run1}, e);
      end
    end
    if (expq1.size() > 0) begin
      e = expq1.pop_front();
      tests++;
      if ({t4, sel4, blink4, alarm4, run4} !== e) begin
        fails++;
        $display("FAIL presc4_outputs t=%0t: got %h expected %h", $time,
                 {t4, sel4, blink4, alarm4, run4}, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    bit [4:0] b;
    bit r, en;
    reset = 1'b1; enable = 1'b0;
    {push_m, push_u, push_d, push_l, push_r} = 5'b0;

    // reset state, then IDLE -> SET
    step(1'b1, 1'b1, 5'b0);
    step(1'b1, 1'b1, 5'b0);
    settle();
    chk("reset_time", 32'(t1), 32'h0);
    chk("reset_alarm_blink", 32'({alarm1, blink1, run1}), 32'h0);
    step(1'b0, 1'b1, 5'b0);
    settle();
    chk("idle_to_set", 32'(blink1), 32'h1);

    // digit set and wrap
    press(BR);
    settle();
    chk("r_wraps_sel", 32'(sel1), 32'h3);
    repeat (6) press(BU);
    settle();
    chk("min_tens_wrap", 32'(t1), 32'h0);
    press(BL);
    press(BD);
    settle();
    chk("sec_units_dec_wrap", 32'(t1), 32'h0009);
    repeat (3) step(1'b0, 1'b1, BU);
    step(1'b0, 1'b1, 5'b0);
    settle();
    chk("held_u_once", 32'(t1), 32'h0000);

    // zero start ignored
    press(BM);
    settle();
    chk("zero_start_ignored", 32'({blink1, run1}), 32'b10);

    // borrow chain 10:00
    press(BR);
    press(BU);
    step(1'b0, 1'b1, BM);
    step(1'b0, 1'b1, 5'b0);
    settle();
    chk("borrow_0959", 32'(t1), 32'h0959);
    step(1'b0, 1'b1, 5'b0);
    settle();
    chk("borrow_0958", 32'(t1), 32'h0958);
    chk("running_flag", 32'(run1), 32'h1);

    // enable drop mid-RUN
    step(1'b0, 1'b0, 5'b0);
    settle();
    chk("enable_clear", 32'({t1, sel1, run1}), 32'h0);

    // 00:10 -> 00:09
    step(1'b0, 1'b1, 5'b0);
    press(BL);
    press(BU);
    step(1'b0, 1'b1, BM);
    step(1'b0, 1'b1, 5'b0);
    settle();
    chk("borrow_0009", 32'(t1), 32'h0009);

    // expiry from 00:02
    step(1'b0, 1'b0, 5'b0);
    step(1'b0, 1'b1, 5'b0);
    press(BU);
    press(BU);
    step(1'b0, 1'b1, BM);
    step(1'b0, 1'b1, 5'b0);
    settle();
    chk("expiry_0001", 32'(t1), 32'h0001);
    step(1'b0, 1'b1, 5'b0);
    settle();
    chk("expiry_0000", 32'(t1), 32'h0000);
    chk("alarm_high", 32'({alarm1, run1}), 32'b10);
    repeat (3) step(1'b0, 1'b1, 5'b0);
    press(BM);
    settle();
    chk("ack_restores_preset", 32'({t1, blink1, alarm1}), {14'h0, 16'h0002, 2'b10});

    // pause mid-interval with PRESC=4
    step(1'b0, 1'b0, 5'b0);
    step(1'b0, 1'b1, 5'b0);
    press(BU);
    press(BU);
    step(1'b0, 1'b1, BM);
    step(1'b0, 1'b1, 5'b0);
    step(1'b0, 1'b1, 5'b0);
    step(1'b0, 1'b1, BM);
    repeat (20) step(1'b0, 1'b1, 5'b0);
    settle();
    chk("pause_hold_time", 32'({t4, run4}), {15'h0, 16'h0002, 1'b0});
    step(1'b0, 1'b1, BM);
    step(1'b0, 1'b1, 5'b0);
    settle();
    chk("resume_partial_a", 32'(t4), 32'h0002);
    step(1'b0, 1'b1, 5'b0);
    settle();
    chk("resume_partial_b", 32'(t4), 32'h0001);

    // async reset mid-RUN, then release
    step(1'b1, 1'b1, 5'b0);
    settle();
    chk("reset_mid_run", 32'({t4, alarm4, run4, blink4}), 32'h0);
    step(1'b0, 1'b1, 5'b0);
    settle();
    chk("reset_release_set", 32'(blink4), 32'h1);

    // m and u together: only m acts
    press(BU);
    step(1'b0, 1'b1, BM | BU);
    settle();
    chk("m_over_u", 32'({t1, run1}), {15'h0, 16'h0001, 1'b1});
    step(1'b0, 1'b1, 5'b0);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      for (int j = 0; j < 5; j++) b[j] = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 399) == 0);
      en = ($urandom_range(0, 199) != 0);
      step(r, en, b);
    end
    step(1'b0, 1'b1, 5'b0);
    settle();
    chk("scoreboard_drained", 32'(expq0.size() + expq1.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- BCD MM:SS countdown timer service. It is the down-counting counterpart of the stopwatch service and shares the same 16-bit display word format.
- The user programs a start time digit by digit, then starts and pauses with push_m. On reaching 00:00 the block raises alarm.
- The time_bcd output feeds the shared segment display path, the same way the stopwatch count does.

Parameters:
- PRESC, 1: clk cycles per one-second decrement in RUN. Must be at least 1.
- PW, 16: prescaler counter width. Must satisfy 2^PW >= PRESC.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  service select (SPDT). Low: synchronous clear to IDLE.
- push_m  in  1  start/pause/acknowledge button, level
- push_u  in  1  increment selected digit, level
- push_d  in  1  decrement selected digit, level
- push_l  in  1  move digit select left, level
- push_r  in  1  move digit select right, level
- time_bcd  out  16  [15:12] min tens, [11:8] min units, [7:4] sec tens, [3:0] sec units
- digit_sel  out  2  selected digit; 3 = [15:12], 0 = [3:0]
- blink_en  out  1  high in SET; display blinks digit_sel
- alarm  out  1  high in EXPIRED
- running  out  1  high in RUN

Behaviour:
- Reset:
  - Interface: reset is asynchronous and active-high; clock is clk.
  - On reset: state=IDLE, time_bcd=0, preset=0, digit_sel=0, prescaler=0, all button history=0, blink_en=0, alarm=0, running=0.
- enable low at any clock edge: same values as reset, applied synchronously. This has priority over every button.
- Button events:
  - Each button's event is a one-cycle rising-edge pulse from a registered sample: press = btn & ~btn_q.
  - A button held high produces exactly one event.
  - When several events occur in the same cycle, only the highest-priority one acts: m > u > d > l > r.
- Digit limits: [15:12] 0-5, [11:8] 0-9, [7:4] 0-5, [3:0] 0-9. No digit ever holds a value outside its limit.
- States: IDLE, SET, RUN, PAUSE, EXPIRED.
- IDLE -> SET on the first edge with enable high.
- SET:
  - u: selected digit +1, wrapping max -> 0.
  - d: selected digit -1, wrapping 0 -> max.
  - l: digit_sel +1 mod 4. r: digit_sel -1 mod 4.
  - m with time_bcd != 0: preset <= time_bcd, prescaler <= 0, go to RUN.
  - m with time_bcd == 0: ignored.
- RUN:
  - prescaler counts 0..PRESC-1. The decrement fires on the edge where prescaler == PRESC-1; prescaler then returns to 0.
  - Decrement uses BCD borrow: sec units 0 -> 9 with borrow; sec tens 0 -> 5 with borrow; min units 0 -> 9 with borrow; min tens decrements.
  - A decrement that produces 0000 moves to EXPIRED on the same edge. alarm is registered and is high from the next cycle.
  - m: go to PAUSE; the prescaler holds its value.
  - If a decrement and m occur in the same cycle, the decrement is applied and then the block pauses.
- PAUSE:
  - time and prescaler hold.
  - m: resume RUN from the held prescaler value.
  - l or r: go to SET with digit_sel unchanged.
  - u and d are ignored.
- EXPIRED:
  - time_bcd = 0000 and alarm = 1; both hold.
  - m: time_bcd <= preset, go to SET, alarm drops.
- running=1 only in RUN; blink_en=1 only in SET.
- The state encoding is 3-bit. Any unused encoding recovers to IDLE on the next edge.

Decomposition:
- Shared package: state encodings (IDLE, SET, RUN, PAUSE, EXPIRED) and per-digit BCD limit constants.
- Shared with the stopwatch service: the 16-bit BCD field boundaries.
- One sub-module: btn_edge_detect (per-button registered rising-edge pulse, async reset). Instantiate it for all five buttons.
- The BCD decrement and digit increment/decrement stay as functions or combinational logic inside countdown_timer.

Test Plan (PRESC=1 unless noted):
- Reset and enable: assert reset mid-RUN, then release with enable=1. Expect time_bcd=0000, alarm=0, IDLE, then SET one cycle later. Drop enable mid-RUN: synchronous clear on the next edge.
- Digit set and wrap:
  - In SET, u pressed 6 times at digit_sel=3 gives [15:12]=0 (wrap after 5).
  - r from 0 gives digit_sel=3.
  - d at digit_sel=0 from 0 gives [3:0]=9.
  - A held button increments only once.
- Borrow chain: set 10:00, press m. Next decrements read 09:59, then 09:58.
  - Set 00:10: reads 00:09 after one decrement.
- Expiry:
  - Set 00:02 and press m. time_bcd reads 00:01, then 00:00 with the state in EXPIRED. alarm=1 the following cycle.
  - m then restores 00:02 in SET with alarm=0.
- Pause/priority:
  - With PRESC=4, pressing m mid-interval pauses; time holds for 20 cycles. Resuming completes the remaining interval only.
  - m and u pressed in the same cycle: only m acts.
- Zero start ignored: in SET with 00:00, pressing m leaves the state in SET and running=0.
